// File: rtl/pa_riscv.sv
// -----------------------------------------------------------------------------
// pa_riscv
// Shared RV32I core definitions: data width, register address width and the
// register address type used by the register file and its read ports.
// No ports (package).
// -----------------------------------------------------------------------------
package pa_riscv;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] regAddr_t;

    // Hard-wired zero register
    localparam regAddr_t X0 = '0;

endpackage : pa_riscv

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file. It forces x0 to zero and,
// when BYPASS is set, forwards the data being written this cycle if the write
// targets the same register.
// Ports:
//   i_addr    read address
//   i_stored  value currently held in the addressed register (ignored for x0)
//   i_wrEn    effective write this cycle (already gated against x0 and reset)
//   i_wrAddr  write address
//   i_wrData  write data
//   o_data    read data
// -----------------------------------------------------------------------------
module regfile_read_port
    import pa_riscv::*;
#(
    parameter logic        BYPASS = 1'b1,
    parameter int unsigned XLEN   = pa_riscv::XLEN
) (
    input  regAddr_t          i_addr,
    input  logic [XLEN-1:0]   i_stored,
    input  logic              i_wrEn,
    input  regAddr_t          i_wrAddr,
    input  logic [XLEN-1:0]   i_wrData,
    output logic [XLEN-1:0]   o_data
);

    // x0 wins over everything, then the same-cycle forward, then storage.
    // i_wrEn is false for x0 writes, so the forward can never revive x0.
    always_comb begin
        o_data = i_stored;
        if (i_addr == X0) begin
            o_data = '0;
        end else if (BYPASS && i_wrEn && (i_wrAddr == i_addr)) begin
            o_data = i_wrData;
        end
    end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 32 x XLEN RV32I integer register file with two read ports, a debug read port
// and one write port. x0 has no storage and always reads zero.
// Ports:
//   i_clk          clock, writes on rising edge
//   i_rst          asynchronous active-high reset, clears x1..x31
//   i_rs1Addr      read port A address
//   i_rs2Addr      read port B address
//   i_rdAddr       write address
//   i_rdData       write data
//   i_regWrite     write enable
//   i_dbgAddr      debug read address
//   o_rs1Data      read data A
//   o_rs2Data      read data B
//   o_dbgData      debug read data
//   o_writeStrobe  high for one cycle after an effective write
//   o_lastRd       address of the last effective write
// -----------------------------------------------------------------------------
module register_file
    import pa_riscv::*;
#(
    parameter logic        BYPASS = 1'b1,
    parameter int unsigned XLEN   = pa_riscv::XLEN
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [4:0]        i_rs1Addr,
    input  logic [4:0]        i_rs2Addr,
    input  logic [4:0]        i_rdAddr,
    input  logic [XLEN-1:0]   i_rdData,
    input  logic              i_regWrite,
    input  logic [4:0]        i_dbgAddr,
    output logic [XLEN-1:0]   o_rs1Data,
    output logic [XLEN-1:0]   o_rs2Data,
    output logic [XLEN-1:0]   o_dbgData,
    output logic              o_writeStrobe,
    output logic [4:0]        o_lastRd
);

    logic [XLEN-1:0] regs_q [1:31];
    logic            writeStrobe_q;
    logic            writeStrobe_d;
    regAddr_t        lastRd_q;
    regAddr_t        lastRd_d;
    logic            wrEn;
    logic [XLEN-1:0] rs1Stored;
    logic [XLEN-1:0] rs2Stored;
    logic [XLEN-1:0] dbgStored;

    // The enable is resolved before address or data are looked at, so an
    // unknown address or data with i_regWrite low can never reach storage.
    assign wrEn = i_regWrite && (i_rdAddr != X0) && !i_rst;

    // Storage lookup by explicit compare so that x0 never indexes the array.
    always_comb begin
        rs1Stored = '0;
        rs2Stored = '0;
        dbgStored = '0;
        for (int i = 1; i < 32; i++) begin
            if (i_rs1Addr == regAddr_t'(i)) rs1Stored = regs_q[i];
            if (i_rs2Addr == regAddr_t'(i)) rs2Stored = regs_q[i];
            if (i_dbgAddr == regAddr_t'(i)) dbgStored = regs_q[i];
        end
    end

    // Register array: reset clears every register immediately, otherwise the
    // single addressed register takes the write data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wrEn && (i_rdAddr == regAddr_t'(i))) begin
                    regs_q[i] <= i_rdData;
                end
            end
        end
    end

    // Write status: a dropped x0 write leaves the last address untouched.
    always_comb begin
        writeStrobe_d = wrEn;
        lastRd_d      = wrEn ? i_rdAddr : lastRd_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            writeStrobe_q <= 1'b0;
            lastRd_q      <= X0;
        end else begin
            writeStrobe_q <= writeStrobe_d;
            lastRd_q      <= lastRd_d;
        end
    end

    assign o_writeStrobe = writeStrobe_q;
    assign o_lastRd      = lastRd_q;

    regfile_read_port #(.BYPASS(BYPASS), .XLEN(XLEN)) u_rs1Port (
        .i_addr   (i_rs1Addr),
        .i_stored (rs1Stored),
        .i_wrEn   (wrEn),
        .i_wrAddr (i_rdAddr),
        .i_wrData (i_rdData),
        .o_data   (o_rs1Data)
    );

    regfile_read_port #(.BYPASS(BYPASS), .XLEN(XLEN)) u_rs2Port (
        .i_addr   (i_rs2Addr),
        .i_stored (rs2Stored),
        .i_wrEn   (wrEn),
        .i_wrAddr (i_rdAddr),
        .i_wrData (i_rdData),
        .o_data   (o_rs2Data)
    );

    regfile_read_port #(.BYPASS(BYPASS), .XLEN(XLEN)) u_dbgPort (
        .i_addr   (i_dbgAddr),
        .i_stored (dbgStored),
        .i_wrEn   (wrEn),
        .i_wrAddr (i_rdAddr),
        .i_wrData (i_rdData),
        .o_data   (o_dbgData)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
// Drives one stimulus stream into two register files, one with write-through
// forwarding and one without, and checks both against hand-computed values
// and a golden array model.
// -----------------------------------------------------------------------------
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;
    logic        regWrite;
    logic [4:0]  dbgAddr;

    logic [31:0] bRs1, bRs2, bDbg;
    logic        bStrobe;
    logic [4:0]  bLast;
    logic [31:0] nRs1, nRs2, nDbg;
    logic        nStrobe;
    logic [4:0]  nLast;

    int assertCount;
    int failCount;

    register_file #(.BYPASS(1'b1)) u_byp (
        .i_clk(clk), .i_rst(rst), .i_rs1Addr(rs1Addr), .i_rs2Addr(rs2Addr),
        .i_rdAddr(rdAddr), .i_rdData(rdData), .i_regWrite(regWrite),
        .i_dbgAddr(dbgAddr), .o_rs1Data(bRs1), .o_rs2Data(bRs2),
        .o_dbgData(bDbg), .o_writeStrobe(bStrobe), .o_lastRd(bLast)
    );

    register_file #(.BYPASS(1'b0)) u_nob (
        .i_clk(clk), .i_rst(rst), .i_rs1Addr(rs1Addr), .i_rs2Addr(rs2Addr),
        .i_rdAddr(rdAddr), .i_rdData(rdData), .i_regWrite(regWrite),
        .i_dbgAddr(dbgAddr), .o_rs1Data(nRs1), .o_rs2Data(nRs2),
        .o_dbgData(nDbg), .o_writeStrobe(nStrobe), .o_lastRd(nLast)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge, outputs are sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
        regWrite = 1'b1; rdAddr = a; rdData = d;
        tick();
        regWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; regWrite = 1'b0; rdAddr = '0; rdData = '0;
        rs1Addr = '0; rs2Addr = '0; dbgAddr = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int i = 1; i < 32; i++) writeReg(5'(i), 32'h1000_0000 + 32'(i));
        // last write leaves the strobe high when reset hits between edges
        regWrite = 1'b1; rdAddr = 5'd9; rdData = 32'h0000_1234;
        tick();
        regWrite = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        assertCount++; if (bStrobe !== 1'b0) begin failCount++; $display("[TB] FAIL reset_strobe_byp got %0b exp 0", bStrobe); end
        assertCount++; if (nStrobe !== 1'b0) begin failCount++; $display("[TB] FAIL reset_strobe_nob got %0b exp 0", nStrobe); end
        assertCount++; if (bLast !== 5'd0) begin failCount++; $display("[TB] FAIL reset_lastRd got %0d exp 0", bLast); end
        for (int a = 0; a < 32; a++) begin
            rs1Addr = 5'(a); rs2Addr = 5'(31 - a); dbgAddr = 5'(a);
            #1;
            assertCount++; if (bRs1 !== 32'h0 || nRs1 !== 32'h0) begin failCount++; $display("[TB] FAIL reset_rs1 x%0d got %h/%h exp 0", a, bRs1, nRs1); end
            assertCount++; if (bRs2 !== 32'h0 || nRs2 !== 32'h0) begin failCount++; $display("[TB] FAIL reset_rs2 x%0d got %h/%h exp 0", 31 - a, bRs2, nRs2); end
            assertCount++; if (bDbg !== 32'h0 || nDbg !== 32'h0) begin failCount++; $display("[TB] FAIL reset_dbg x%0d got %h/%h exp 0", a, bDbg, nDbg); end
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        writeReg(5'd5, 32'hDEAD_BEEF);
        rs1Addr = 5'd5;
        #1;
        assertCount++; if (bRs1 !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL wr_rd_rs1_byp got %h exp deadbeef", bRs1); end
        assertCount++; if (nRs1 !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL wr_rd_rs1_nob got %h exp deadbeef", nRs1); end
        assertCount++; if (bStrobe !== 1'b1 || nStrobe !== 1'b1) begin failCount++; $display("[TB] FAIL wr_rd_strobe got %0b/%0b exp 1", bStrobe, nStrobe); end
        assertCount++; if (bLast !== 5'd5 || nLast !== 5'd5) begin failCount++; $display("[TB] FAIL wr_rd_lastRd got %0d/%0d exp 5", bLast, nLast); end
        tick();
        assertCount++; if (bStrobe !== 1'b0) begin failCount++; $display("[TB] FAIL wr_rd_strobe_drop got %0b exp 0", bStrobe); end
    endtask

    task automatic test_x0_write();
        regWrite = 1'b1; rdAddr = 5'd0; rdData = 32'hFFFF_FFFF;
        rs1Addr = 5'd0; rs2Addr = 5'd0; dbgAddr = 5'd0;
        #1;
        assertCount++; if (bRs1 !== 32'h0 || bRs2 !== 32'h0 || bDbg !== 32'h0) begin failCount++; $display("[TB] FAIL x0_forward got %h/%h/%h exp 0", bRs1, bRs2, bDbg); end
        tick();
        regWrite = 1'b0;
        #1;
        assertCount++; if (bRs1 !== 32'h0 || nRs1 !== 32'h0) begin failCount++; $display("[TB] FAIL x0_read got %h/%h exp 0", bRs1, nRs1); end
        assertCount++; if (bStrobe !== 1'b0 || nStrobe !== 1'b0) begin failCount++; $display("[TB] FAIL x0_strobe got %0b/%0b exp 0", bStrobe, nStrobe); end
        assertCount++; if (bLast !== 5'd5 || nLast !== 5'd5) begin failCount++; $display("[TB] FAIL x0_lastRd got %0d/%0d exp 5", bLast, nLast); end
    endtask

    task automatic test_hazard();
        writeReg(5'd7, 32'h0000_0001);
        regWrite = 1'b1; rdAddr = 5'd7; rdData = 32'h0000_0002;
        rs1Addr = 5'd7; rs2Addr = 5'd7; dbgAddr = 5'd7;
        #1;
        assertCount++; if (bRs1 !== 32'h2 || bRs2 !== 32'h2) begin failCount++; $display("[TB] FAIL hazard_byp got %h/%h exp 2", bRs1, bRs2); end
        assertCount++; if (bDbg !== 32'h2) begin failCount++; $display("[TB] FAIL hazard_byp_dbg got %h exp 2", bDbg); end
        assertCount++; if (nRs1 !== 32'h1 || nRs2 !== 32'h1) begin failCount++; $display("[TB] FAIL hazard_nob got %h/%h exp 1", nRs1, nRs2); end
        assertCount++; if (nDbg !== 32'h1) begin failCount++; $display("[TB] FAIL hazard_nob_dbg got %h exp 1", nDbg); end
        tick();
        regWrite = 1'b0;
        #1;
        assertCount++; if (nRs1 !== 32'h2 || nRs2 !== 32'h2) begin failCount++; $display("[TB] FAIL hazard_nob_next got %h/%h exp 2", nRs1, nRs2); end
        assertCount++; if (bRs1 !== 32'h2 || bRs2 !== 32'h2) begin failCount++; $display("[TB] FAIL hazard_byp_next got %h/%h exp 2", bRs1, bRs2); end
        assertCount++; if (bLast !== 5'd7 || nStrobe !== 1'b1) begin failCount++; $display("[TB] FAIL hazard_status got last %0d strobe %0b exp 7/1", bLast, nStrobe); end
    endtask

    task automatic test_alu_hookup();
        logic sltResult;
        writeReg(5'd1, 32'h7FFF_FFFF);
        writeReg(5'd2, 32'hFFFF_FFFF);
        // concurrent write to another register must not leak into A or B
        regWrite = 1'b1; rdAddr = 5'd3; rdData = 32'h0000_0055;
        rs1Addr = 5'd1; rs2Addr = 5'd2;
        #1;
        assertCount++; if (bRs1 !== 32'h7FFF_FFFF || nRs1 !== 32'h7FFF_FFFF) begin failCount++; $display("[TB] FAIL alu_a got %h/%h exp 7fffffff", bRs1, nRs1); end
        assertCount++; if (bRs2 !== 32'hFFFF_FFFF || nRs2 !== 32'hFFFF_FFFF) begin failCount++; $display("[TB] FAIL alu_b got %h/%h exp ffffffff", bRs2, nRs2); end
        sltResult = ($signed(bRs1) < $signed(bRs2));
        assertCount++; if (sltResult !== 1'b0) begin failCount++; $display("[TB] FAIL alu_slt got %0b exp 0", sltResult); end
        tick();
        regWrite = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        rst = 1'b1; regWrite = 1'b1; rdAddr = 5'd3; rdData = 32'hA5A5_A5A5;
        tick();
        assertCount++; if (bStrobe !== 1'b0 || nStrobe !== 1'b0) begin failCount++; $display("[TB] FAIL rst_wr_strobe got %0b/%0b exp 0", bStrobe, nStrobe); end
        rst = 1'b0; regWrite = 1'b0; rs1Addr = 5'd3; dbgAddr = 5'd3;
        #1;
        assertCount++; if (bRs1 !== 32'h0 || nRs1 !== 32'h0) begin failCount++; $display("[TB] FAIL rst_wr_x3 got %h/%h exp 0", bRs1, nRs1); end
        tick();
        assertCount++; if (nDbg !== 32'h0 || bStrobe !== 1'b0 || bLast !== 5'd0) begin failCount++; $display("[TB] FAIL rst_wr_after got dbg %h strobe %0b last %0d exp 0/0/0", nDbg, bStrobe, bLast); end
        // first edge after release writes normally
        rst = 1'b1;
        tick();
        rst = 1'b0; regWrite = 1'b1; rdAddr = 5'd4; rdData = 32'h0000_0044; rs1Addr = 5'd4;
        tick();
        regWrite = 1'b0;
        #1;
        assertCount++; if (nRs1 !== 32'h44 || bRs1 !== 32'h44) begin failCount++; $display("[TB] FAIL release_write got %h/%h exp 44", nRs1, bRs1); end
        assertCount++; if (nStrobe !== 1'b1 || nLast !== 5'd4) begin failCount++; $display("[TB] FAIL release_status got strobe %0b last %0d exp 1/4", nStrobe, nLast); end
    endtask

    task automatic test_random();
        logic [31:0] model [0:31];
        logic [4:0]  lastExp;
        logic        we;
        logic [31:0] e1b, e2b, edb, e1n, e2n, edn;
        rst = 1'b1; regWrite = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        lastExp = '0;
        for (int c = 0; c < 10000; c++) begin
            regWrite = 1'($urandom_range(0, 1));
            rs1Addr = 5'($urandom_range(0, 31));
            rs2Addr = ($urandom_range(0, 3) == 0) ? rs1Addr : 5'($urandom_range(0, 31));
            dbgAddr = 5'($urandom_range(0, 31));
            if (regWrite) begin
                rdAddr = ($urandom_range(0, 3) == 0) ? rs1Addr : 5'($urandom_range(0, 31));
                rdData = $urandom;
            end else begin
                rdAddr = 'x;
                rdData = 'x;
            end
            #1;
            we  = regWrite && (rdAddr != 5'd0);
            e1n = (rs1Addr == 5'd0) ? 32'h0 : model[rs1Addr];
            e2n = (rs2Addr == 5'd0) ? 32'h0 : model[rs2Addr];
            edn = (dbgAddr == 5'd0) ? 32'h0 : model[dbgAddr];
            e1b = (we && rdAddr == rs1Addr) ? rdData : e1n;
            e2b = (we && rdAddr == rs2Addr) ? rdData : e2n;
            edb = (we && rdAddr == dbgAddr) ? rdData : edn;
            assertCount++; if (bRs1 !== e1b || bRs2 !== e2b || bDbg !== edb) begin failCount++; $display("[TB] FAIL rand_byp cyc %0d got %h/%h/%h exp %h/%h/%h", c, bRs1, bRs2, bDbg, e1b, e2b, edb); end
            assertCount++; if (nRs1 !== e1n || nRs2 !== e2n || nDbg !== edn) begin failCount++; $display("[TB] FAIL rand_nob cyc %0d got %h/%h/%h exp %h/%h/%h", c, nRs1, nRs2, nDbg, e1n, e2n, edn); end
            if (we) begin
                model[rdAddr] = rdData;
                lastExp = rdAddr;
            end
            tick();
            assertCount++; if (bStrobe !== we || nStrobe !== we || bLast !== lastExp || nLast !== lastExp) begin failCount++; $display("[TB] FAIL rand_status cyc %0d got %0b/%0b %0d/%0d exp %0b %0d", c, bStrobe, nStrobe, bLast, nLast, we, lastExp); end
        end
        regWrite = 1'b0;
    endtask

    initial begin
        assertCount = 0;
        failCount = 0;
        test_reset();
        test_write_read();
        test_x0_write();
        test_hazard();
        test_alu_hookup();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout after %0d assertions", assertCount);
        $fatal(1, "[TB] timeout");
    end

endmodule : tb_register_file
